// File: rtl/fifo_wr_ingress_if.sv
// Upstream valid/ready beat channel into the write-side ingress stage.
interface fifo_wr_ingress_if #(
  parameter int unsigned DSIZE = 8
);
  logic             s_valid;
  logic [DSIZE-1:0] s_data;
  logic             s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/fifo_wr_ingress.sv
// Write-side ingress: two-entry skid buffer feeding the FIFO write port, with
// optional write/stall statistics enabled by FIFO_WR_INGRESS_STATS_EN.
module fifo_wr_ingress #(
  parameter int unsigned DSIZE       = 8,
  parameter bit          AF_THROTTLE = 1'b1
) (
  input  logic              wclk,
  input  logic              wrst_n,
  fifo_wr_ingress_if.slave  s,
  input  logic              wflush,
  input  logic              wfull,
  input  logic              walmostfull,
  output logic              winc,
  output logic [DSIZE-1:0]  wdata,
  input  logic              stats_clr,
  output logic [15:0]       wr_count,
  output logic [15:0]       stall_count
);

  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    SKID = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DSIZE-1:0] out_q, out_d;
  logic [DSIZE-1:0] skid_q, skid_d;
  logic             winc_q, winc_d;
  logic             s_ready_c;
  logic             accept_c;
  logic             consume_c;

  // Ready never looks at s_valid; reset and flush both close the door.
  assign s_ready_c = wrst_n && (state_q != SKID) && !(AF_THROTTLE && walmostfull) && !wflush;
  assign accept_c  = s.s_valid && s_ready_c;
  assign consume_c = winc_q && !wfull;
  assign s.s_ready = s_ready_c;

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      skid_q  <= '0;
      winc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      winc_q  <= winc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = BUSY;
      BUSY: begin
        if (accept_c && !consume_c)      state_d = SKID;
        else if (!accept_c && consume_c) state_d = IDLE;
      end
      SKID:    if (consume_c) state_d = BUSY;
      default: state_d = IDLE;
    endcase
    if (wflush) state_d = IDLE;
  end

  // Datapath loads; flush wipes both entries regardless of handshakes.
  always_comb begin
    out_d  = out_q;
    skid_d = skid_q;
    case (state_q)
      IDLE: if (accept_c) out_d = s.s_data;
      BUSY: begin
        if (accept_c && consume_c) out_d  = s.s_data;
        else if (accept_c)         skid_d = s.s_data;
      end
      SKID: if (consume_c) out_d = skid_q;
      default: ;
    endcase
    if (wflush) begin
      out_d  = '0;
      skid_d = '0;
    end
    winc_d = (state_d != IDLE);
  end

  assign winc  = winc_q;
  assign wdata = out_q;

`ifdef FIFO_WR_INGRESS_STATS_EN
  logic [CW-1:0] wr_count_q, wr_count_d;
  logic [CW-1:0] stall_count_q, stall_count_d;
  logic          stall_c;

  assign stall_c = winc_q && wfull;

  // Saturating counters; clear wins over a same-cycle increment.
  always_comb begin
    wr_count_d    = wr_count_q;
    stall_count_d = stall_count_q;
    if (stats_clr) begin
      wr_count_d    = '0;
      stall_count_d = '0;
    end else begin
      if (consume_c && (wr_count_q != {CW{1'b1}}))  wr_count_d    = wr_count_q + CW'(1);
      if (stall_c && (stall_count_q != {CW{1'b1}})) stall_count_d = stall_count_q + CW'(1);
    end
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wr_count_q    <= '0;
      stall_count_q <= '0;
    end else begin
      wr_count_q    <= wr_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign wr_count    = wr_count_q;
  assign stall_count = stall_count_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign wr_count         = '0;
  assign stall_count      = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_ingress.sv
// Directed bench for fifo_wr_ingress: vector table plus hand-written streaming,
// throttle, write-order and counter saturation sequences.
module tb_fifo_wr_ingress;
  localparam int unsigned DSIZE = 8;
`ifdef FIFO_WR_INGRESS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             wclk = 1'b0;
  logic             wrst_n, s_valid, wflush, wfull, walmostfull, stats_clr;
  logic [DSIZE-1:0] s_data;
  logic             winc, winc0;
  logic [DSIZE-1:0] wdata, wdata0;
  logic [15:0]      wr_count, stall_count, wr_count0, stall_count0;

  always #5 wclk = ~wclk;

  fifo_wr_ingress_if #(.DSIZE(DSIZE)) sif ();
  fifo_wr_ingress_if #(.DSIZE(DSIZE)) sif0 ();
  assign sif.s_valid  = s_valid;
  assign sif.s_data   = s_data;
  assign sif0.s_valid = s_valid;
  assign sif0.s_data  = s_data;

  fifo_wr_ingress #(.DSIZE(DSIZE), .AF_THROTTLE(1'b1)) u_dut (
    .wclk(wclk), .wrst_n(wrst_n), .s(sif.slave), .wflush(wflush), .wfull(wfull),
    .walmostfull(walmostfull), .winc(winc), .wdata(wdata), .stats_clr(stats_clr),
    .wr_count(wr_count), .stall_count(stall_count));

  fifo_wr_ingress #(.DSIZE(DSIZE), .AF_THROTTLE(1'b0)) u_dut0 (
    .wclk(wclk), .wrst_n(wrst_n), .s(sif0.slave), .wflush(wflush), .wfull(wfull),
    .walmostfull(walmostfull), .winc(winc0), .wdata(wdata0), .stats_clr(stats_clr),
    .wr_count(wr_count0), .stall_count(stall_count0));

  typedef struct {
    logic       rst_n, v;
    logic [7:0] d;
    logic       full, af, flush, clr;
    logic       exp_rdy, exp_winc;
    logic [7:0] exp_wdata;
    logic [15:0] exp_wr, exp_stall;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] log_q[$];
  bit         log_en = 1'b1;

  // Record every beat that the FIFO memory actually takes.
  always @(negedge wclk)
    if (log_en && winc === 1'b1 && wfull === 1'b0) log_q.push_back(wdata);

  function automatic vec_t mk(logic rst_n, logic v, logic [7:0] d, logic full, logic af,
                              logic flush, logic clr, logic rdy, logic wi, logic [7:0] wd,
                              logic [15:0] wr, logic [15:0] st);
    vec_t r;
    r.rst_n = rst_n; r.v = v; r.d = d; r.full = full; r.af = af; r.flush = flush;
    r.clr = clr; r.exp_rdy = rdy; r.exp_winc = wi; r.exp_wdata = wd;
    r.exp_wr = STATS ? wr : 16'h0;
    r.exp_stall = STATS ? st : 16'h0;
    return r;
  endfunction

  function automatic logic [15:0] cnt(logic [15:0] x);
    return STATS ? x : 16'h0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic apply(input vec_t t, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    wrst_n = t.rst_n; s_valid = t.v; s_data = t.d; wfull = t.full;
    walmostfull = t.af; wflush = t.flush; stats_clr = t.clr;
    #1;
    chk({tag, ".s_ready"}, 32'(sif.s_ready), 32'(t.exp_rdy));
    tick();
    chk({tag, ".winc"}, 32'(winc), 32'(t.exp_winc));
    chk({tag, ".wdata"}, 32'(wdata), 32'(t.exp_wdata));
    chk({tag, ".wr_count"}, 32'(wr_count), 32'(t.exp_wr));
    chk({tag, ".stall_count"}, 32'(stall_count), 32'(t.exp_stall));
  endtask

  initial begin
    logic [7:0] exp_log[$];

    //           rst v  d      full af fl clr  rdy winc wdata  wr st
    vecs[0]  = mk(1, 1, 8'hA1, 0, 0, 0, 0,  1, 1, 8'hA1, 0, 0);
    vecs[1]  = mk(1, 1, 8'hA2, 1, 0, 0, 0,  1, 1, 8'hA1, 0, 1);
    vecs[2]  = mk(1, 1, 8'hA3, 1, 0, 0, 0,  0, 1, 8'hA1, 0, 2);
    vecs[3]  = mk(1, 1, 8'hA3, 1, 0, 0, 0,  0, 1, 8'hA1, 0, 3);
    vecs[4]  = mk(1, 1, 8'hA3, 1, 0, 0, 0,  0, 1, 8'hA1, 0, 4);
    vecs[5]  = mk(1, 1, 8'hA3, 1, 0, 0, 0,  0, 1, 8'hA1, 0, 5);
    vecs[6]  = mk(1, 1, 8'hA3, 0, 0, 0, 0,  0, 1, 8'hA2, 1, 5);
    vecs[7]  = mk(1, 1, 8'hA3, 0, 0, 0, 0,  1, 1, 8'hA3, 2, 5);
    vecs[8]  = mk(1, 0, 8'h00, 0, 0, 0, 0,  1, 0, 8'hA3, 3, 5);
    vecs[9]  = mk(1, 1, 8'h55, 0, 0, 0, 0,  1, 1, 8'h55, 3, 5);
    vecs[10] = mk(1, 1, 8'h66, 1, 0, 0, 0,  1, 1, 8'h55, 3, 6);
    vecs[11] = mk(1, 1, 8'h99, 1, 0, 0, 0,  0, 1, 8'h55, 3, 7);
    vecs[12] = mk(1, 0, 8'h00, 1, 0, 1, 0,  0, 0, 8'h00, 3, 8);
    vecs[13] = mk(1, 0, 8'h00, 0, 0, 0, 0,  1, 0, 8'h00, 3, 8);
    vecs[14] = mk(1, 1, 8'hAB, 0, 0, 1, 0,  0, 0, 8'h00, 3, 8);
    vecs[15] = mk(1, 1, 8'hB1, 0, 1, 0, 0,  0, 0, 8'h00, 3, 8);
    vecs[16] = mk(1, 1, 8'hB1, 0, 0, 0, 0,  1, 1, 8'hB1, 3, 8);
    vecs[17] = mk(1, 1, 8'hB2, 0, 1, 0, 0,  0, 0, 8'hB1, 4, 8);
    vecs[18] = mk(1, 1, 8'hC1, 0, 0, 0, 0,  1, 1, 8'hC1, 4, 8);
    vecs[19] = mk(1, 1, 8'hC2, 1, 0, 0, 0,  1, 1, 8'hC1, 4, 9);
    vecs[20] = mk(0, 1, 8'hC3, 1, 0, 0, 0,  0, 0, 8'h00, 0, 0);
    vecs[21] = mk(1, 1, 8'h77, 0, 0, 0, 0,  1, 1, 8'h77, 0, 0);
    vecs[22] = mk(1, 0, 8'h00, 0, 0, 0, 0,  1, 0, 8'h77, 1, 0);
    vecs[23] = mk(1, 0, 8'h00, 0, 0, 0, 1,  1, 0, 8'h77, 0, 0);

    wrst_n = 1'b0; s_valid = 1'b0; s_data = '0; wflush = 1'b0; wfull = 1'b0;
    walmostfull = 1'b0; stats_clr = 1'b0;
    repeat (2) tick();
    chk("reset.winc", 32'(winc), 32'(0));
    chk("reset.wdata", 32'(wdata), 32'(0));
    chk("reset.s_ready", 32'(sif.s_ready), 32'(0));
    chk("reset.wr_count", 32'(wr_count), 32'(0));
    chk("reset.stall_count", 32'(stall_count), 32'(0));

    for (int i = 0; i < NV; i++) apply(vecs[i], i);

    // Back-to-back stream of 0x01..0x10 with no backpressure.
    for (int i = 1; i <= 16; i++) begin
      s_valid = 1'b1; s_data = 8'(i);
      #1;
      chk($sformatf("stream%0d.s_ready", i), 32'(sif.s_ready), 32'(1));
      tick();
      chk($sformatf("stream%0d.winc", i), 32'(winc), 32'(1));
      chk($sformatf("stream%0d.wdata", i), 32'(wdata), 32'(i));
    end
    s_valid = 1'b0;
    tick();
    chk("stream.winc_idle", 32'(winc), 32'(0));
    chk("stream.wr_count", 32'(wr_count), 32'(cnt(16'd16)));
    chk("stream.stall_count", 32'(stall_count), 32'(cnt(16'd0)));

    // Almost-full throttles only the AF_THROTTLE=1 instance.
    s_valid = 1'b1; s_data = 8'hD1;
    tick();
    s_valid = 1'b0; walmostfull = 1'b1; wfull = 1'b1;
    #1;
    chk("throttle.s_ready_af1", 32'(sif.s_ready), 32'(0));
    chk("throttle.s_ready_af0", 32'(sif0.s_ready), 32'(1));
    chk("throttle.winc_af0", 32'(winc0), 32'(1));
    tick();
    wflush = 1'b1; walmostfull = 1'b0;
    tick();
    wflush = 1'b0; wfull = 1'b0;
    chk("throttle.flush_winc", 32'(winc), 32'(0));
    chk("throttle.flush_winc0", 32'(winc0), 32'(0));

    // Exact sequence of beats taken by the FIFO memory so far.
    exp_log = '{8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'h77};
    for (int i = 1; i <= 16; i++) exp_log.push_back(8'(i));
    chk("log.size", 32'(log_q.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < log_q.size(); i++)
      chk($sformatf("log[%0d]", i), 32'(log_q[i]), 32'(exp_log[i]));

    // Saturation: 65540 consumed beats, then clear with a concurrent consume.
    log_en = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 65541; i++) begin
      s_data = 8'(i);
      tick();
    end
    chk("sat.wr_count", 32'(wr_count), 32'(cnt(16'hFFFF)));
    chk("sat.winc", 32'(winc), 32'(1));
    stats_clr = 1'b1;
    tick();
    chk("clr.wr_count", 32'(wr_count), 32'(cnt(16'd0)));
    chk("clr.winc", 32'(winc), 32'(1));
    stats_clr = 1'b0;
    tick();
    chk("clr.wr_count_after", 32'(wr_count), 32'(cnt(16'd1)));
    s_valid = 1'b0;
    tick();
    chk("end.winc", 32'(winc), 32'(0));
    chk("end.wr_count", 32'(wr_count), 32'(cnt(16'd2)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_wr_ingress.md
FIFO_WR_INGRESS -- requirements
Module: fifo_wr_ingress

Interface
REQ-001 The block SHALL have parameter DSIZE, default 8, write data width in bits.
REQ-002 The block SHALL have parameter AF_THROTTLE, default 1; when 1, walmostfull deasserts s_ready.
REQ-003 wclk  input  1  write-domain clock; all state updates on its rising edge.
REQ-004 wrst_n  input  1  reset, synchronous, active-low.
REQ-005 s_valid  input  1  upstream beat valid.
REQ-006 s_data  input  DSIZE  upstream beat data.
REQ-007 s_ready  output  1  block can accept a beat this cycle.
REQ-008 wflush  input  1  synchronous discard of all buffered beats.
REQ-009 wfull  input  1  registered full flag from the write-pointer stage.
REQ-010 walmostfull  input  1  registered almost-full flag from the write-pointer stage.
REQ-011 winc  output  1  write request to the write-pointer stage and FIFO memory.
REQ-012 wdata  output  DSIZE  data written to the FIFO memory when winc and not wfull.
REQ-013 stats_clr  input  1  synchronous clear of the statistics counters.
REQ-014 wr_count  output  16  count of beats written to the FIFO.
REQ-015 stall_count  output  16  count of cycles with winc high and wfull high.

Function
REQ-016 A beat SHALL be accepted in a cycle where s_valid and s_ready are both high at the rising edge.
REQ-017 A beat SHALL be consumed in a cycle where winc is high and wfull is low; winc and wdata SHALL hold stable until consumed.
REQ-018 The block SHALL implement states IDLE (output empty), BUSY (output register full, skid empty), SKID (both full).
REQ-019 IDLE: accept -> BUSY, beat loaded into output register; otherwise stay IDLE.
REQ-020 BUSY: accept and consume -> BUSY with new beat; accept without consume -> SKID with beat in skid register; consume without accept -> IDLE; neither -> BUSY.
REQ-021 SKID: consume -> BUSY with skid beat moved to output register; otherwise stay SKID.
REQ-022 winc SHALL be high exactly in BUSY and SKID; wdata SHALL be the output register.
REQ-023 s_ready SHALL equal (state != SKID) and not (AF_THROTTLE and walmostfull) and not wflush; it SHALL depend only on registered signals and wflush, never on s_valid.
REQ-024 Latency SHALL be one cycle: a beat accepted at edge N drives winc/wdata from edge N until consumption.
REQ-025 Beat order SHALL be preserved; no beat SHALL be duplicated or lost except by wflush or reset.
REQ-026 wflush high at an edge SHALL force IDLE, discard both registers, and take priority over accept and consume.
REQ-027 wr_count SHALL increment by one per consumed beat and saturate at 16'hFFFF.
REQ-028 stall_count SHALL increment by one per cycle with winc and wfull high and saturate at 16'hFFFF.
REQ-029 stats_clr SHALL zero both counters and take priority over increments in the same cycle.

Reset
REQ-030 With wrst_n low at an edge: state IDLE, winc 0, wdata 0, skid register 0, wr_count 0, stall_count 0.
REQ-031 s_ready SHALL be 0 while wrst_n is low; reset mid-operation SHALL discard buffered beats without any further winc.

Configuration
REQ-032 Macro FIFO_WR_INGRESS_STATS_EN defined: wr_count and stall_count SHALL behave per REQ-027..REQ-029.
REQ-033 Macro FIFO_WR_INGRESS_STATS_EN undefined: no counter registers SHALL exist; wr_count and stall_count SHALL be tied to 0; stats_clr SHALL be ignored; ports SHALL be unchanged.

Verification
REQ-034 Streaming: s_valid high with data 0x01..0x10, wfull and walmostfull low -> winc high from cycle 1, wdata 0x01..0x10 on consecutive cycles, wr_count 16.
REQ-035 Backpressure: beats 0xA1, 0xA2, 0xA3 presented, wfull high from cycle 1 for 5 cycles -> state SKID, s_ready low, 0xA3 held upstream, stall_count 5, then 0xA1, 0xA2, 0xA3 written in order.
REQ-036 Throttle: AF_THROTTLE=1, walmostfull high -> s_ready low within the same cycle; AF_THROTTLE=0 -> s_ready stays high in BUSY.
REQ-037 Flush: SKID holding 0x55, 0x66, wflush pulsed -> next cycle IDLE, winc 0, neither beat written, wr_count unchanged.
REQ-038 Reset mid-stream: wrst_n low for 1 cycle in SKID -> all outputs 0, next accepted beat 0x77 is the first written.
REQ-039 Saturation and clear: 65540 consumed beats -> wr_count 16'hFFFF; stats_clr with concurrent consume -> wr_count 0 next cycle.
